// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 64-bit in-order pipeline.
// Owns the PC, keeps at most one instruction-bus request outstanding, feeds
// decode through an output register backed by a one-entry skid buffer, and
// handles execute redirects, including discarding an in-flight stale response.
//
// Ports:
//   clk, resetn                  clock, async active-low reset
//   ireq_valid, ireq_addr        instruction request (held until data_ok)
//   iresp_data_ok, iresp_data    response pulse + instruction word
//   stall                        decode is not consuming the output this cycle
//   redirect_valid, redirect_pc  flush and refetch from redirect_pc (word aligned)
//   out_valid, out_pc, out_instr bundle presented to decode
//
// state | meaning
// FETCH | request for pc outstanding (or about to be issued after reset)
// HOLD  | skid full, no request outstanding, waiting for decode to drain
// DROP  | stale request still on the bus; pc already holds the redirect target
module fetch_stage #(
  parameter int unsigned      XLEN     = 64,
  parameter logic [XLEN-1:0]  PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            ireq_valid,
  output logic [XLEN-1:0] ireq_addr,
  input  logic            iresp_data_ok,
  input  logic [31:0]     iresp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            ireq_valid_q, ireq_valid_d;
  logic [XLEN-1:0] ireq_addr_q, ireq_addr_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;

  logic            resp_ok;
  logic            out_free;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target;

  // A response only counts while our request is actually on the bus.
  assign resp_ok  = ireq_valid_q & iresp_data_ok;
  assign out_free = ~out_valid_q | ~stall;
  assign pc_inc   = pc_q + XLEN'(4);
  assign target   = redirect_pc & ~XLEN'(3);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ireq_valid_d = ireq_valid_q;
    ireq_addr_d  = ireq_addr_q;
    // Output is consumed whenever stall is low; it survives only if stalled.
    out_valid_d  = out_valid_q & stall;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (redirect_valid) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      pc_d         = target;
      case (state_q)
        ST_FETCH, ST_DROP: begin
          // An outstanding request cannot be withdrawn; if it is still pending,
          // ride it out in DROP. Otherwise issue the target right away.
          if (resp_ok || !ireq_valid_q) begin
            ireq_valid_d = 1'b1;
            ireq_addr_d  = target;
            state_d      = ST_FETCH;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: begin
          ireq_valid_d = 1'b1;
          ireq_addr_d  = target;
          state_d      = ST_FETCH;
        end
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (!ireq_valid_q) begin
            ireq_valid_d = 1'b1;
            ireq_addr_d  = pc_q;
          end else if (resp_ok) begin
            pc_d = pc_inc;
            if (out_free) begin
              out_valid_d = 1'b1;
              out_pc_d    = pc_q;
              out_instr_d = iresp_data;
              ireq_addr_d = pc_inc;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = pc_q;
              skid_instr_d = iresp_data;
              ireq_valid_d = 1'b0;
              state_d      = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall && skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_pc_d     = skid_pc_q;
            out_instr_d  = skid_instr_q;
            skid_valid_d = 1'b0;
            ireq_valid_d = 1'b1;
            ireq_addr_d  = pc_q;
            state_d      = ST_FETCH;
          end
        end
        ST_DROP: begin
          if (resp_ok) begin
            ireq_addr_d = pc_q;
            state_d     = ST_FETCH;
          end
        end
        default: begin
          ireq_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_FETCH;
      pc_q         <= PC_RESET;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = ireq_addr_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized traffic for
// fetch_stage, compared every cycle against a behavioural model.
module tb_fetch_stage;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  fetch_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: what the fetch stage should present after each edge
  logic        m_ireq_valid;
  logic [63:0] m_ireq_addr;
  logic        m_out_valid;
  logic [63:0] m_out_pc;
  logic [31:0] m_out_instr;
  logic [63:0] m_pc;
  logic        m_stale;
  logic [63:0] sk_pc[$];
  logic [31:0] sk_ins[$];

  // bus responder
  int wait_left = -1;
  int lat       = 0;
  bit rand_lat  = 0;
  bit stray     = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] hash(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[63:48]} ^ 32'hC0DE_1234;
  endfunction

  task automatic model_reset();
    m_ireq_valid = 1'b0;
    m_ireq_addr  = '0;
    m_out_valid  = 1'b0;
    m_out_pc     = '0;
    m_out_instr  = '0;
    m_pc         = PC_RST;
    m_stale      = 1'b0;
    sk_pc.delete();
    sk_ins.delete();
    wait_left    = -1;
  endtask

  task automatic model_step(input logic st, input logic rv, input logic [63:0] rpc,
                            input logic dok, input logic [31:0] data);
    logic        acc;
    logic [63:0] tgt;
    if (!resetn) begin
      model_reset();
    end else begin
      acc = m_ireq_valid && dok;
      if (m_out_valid && !st) m_out_valid = 1'b0;
      if (rv) begin
        tgt         = rpc & ~64'd3;
        m_out_valid = 1'b0;
        sk_pc.delete();
        sk_ins.delete();
        m_pc = tgt;
        if (!m_ireq_valid || acc) begin
          m_ireq_valid = 1'b1;
          m_ireq_addr  = tgt;
          m_stale      = 1'b0;
        end else begin
          m_stale = 1'b1;
        end
      end else if (sk_pc.size() != 0) begin
        if (!st) begin
          m_out_valid  = 1'b1;
          m_out_pc     = sk_pc.pop_front();
          m_out_instr  = sk_ins.pop_front();
          m_ireq_valid = 1'b1;
          m_ireq_addr  = m_pc;
        end
      end else if (!m_ireq_valid) begin
        m_ireq_valid = 1'b1;
        m_ireq_addr  = m_pc;
      end else if (acc && m_stale) begin
        m_stale     = 1'b0;
        m_ireq_addr = m_pc;
      end else if (acc) begin
        if (!m_out_valid) begin
          m_out_valid = 1'b1;
          m_out_pc    = m_pc;
          m_out_instr = data;
          m_pc        = m_pc + 64'd4;
          m_ireq_addr = m_pc;
        end else begin
          sk_pc.push_back(m_pc);
          sk_ins.push_back(data);
          m_pc         = m_pc + 64'd4;
          m_ireq_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("ireq_valid", {63'd0, ireq_valid}, {63'd0, m_ireq_valid});
    check_eq("ireq_addr",  ireq_addr, m_ireq_addr);
    check_eq("out_valid",  {63'd0, out_valid}, {63'd0, m_out_valid});
    check_eq("out_pc",     out_pc, m_out_pc);
    check_eq("out_instr",  {32'd0, out_instr}, {32'd0, m_out_instr});
  endtask

  // Called just after a falling edge: drive inputs for the next rising edge,
  // advance the model, then compare at the following falling edge.
  task automatic run(input logic st, input logic rv, input logic [63:0] rpc);
    logic        dok;
    logic [31:0] data;
    if (m_ireq_valid) begin
      if (wait_left < 0) wait_left = rand_lat ? int'($urandom_range(0, 3)) : lat;
      dok = (wait_left == 0);
      if (dok) wait_left = -1;
      else     wait_left--;
    end else begin
      wait_left = -1;
      dok = stray && ($urandom_range(0, 3) == 0);
    end
    data = dok ? hash(m_ireq_addr) : $urandom;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    iresp_data_ok  = dok;
    iresp_data     = data;
    model_step(st, rv, rpc, dok, data);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    resetn = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    iresp_data_ok = 1'b0; iresp_data = '0;
    model_reset();
    @(negedge clk);
    check_all();

    // zero-latency streaming
    resetn = 1'b1;
    lat = 0;
    run(0, 0, 0);
    check_eq("first_req", ireq_addr, PC_RST);
    run(0, 0, 0);
    check_eq("stream_addr1", ireq_addr, 64'h8000_0004);
    check_eq("stream_out0", out_pc, 64'h8000_0000);
    run(0, 0, 0);
    check_eq("stream_addr2", ireq_addr, 64'h8000_0008);
    check_eq("stream_out1", out_pc, 64'h8000_0004);

    // stall while the next response lands: goes to skid, bus goes idle
    run(1, 0, 0);
    check_eq("skid_idle", {63'd0, ireq_valid}, 64'd0);
    check_eq("skid_frozen", out_pc, 64'h8000_0004);
    run(1, 0, 0);
    run(1, 0, 0);
    check_eq("skid_frozen3", out_pc, 64'h8000_0004);
    run(0, 0, 0);
    check_eq("skid_drain_pc", out_pc, 64'h8000_0008);
    check_eq("skid_next_req", ireq_addr, 64'h8000_000C);

    // redirect coincident with data_ok and stall
    run(1, 1, 64'h8000_0400);
    check_eq("redir_dok_valid", {63'd0, out_valid}, 64'd0);
    check_eq("redir_dok_addr", ireq_addr, 64'h8000_0400);

    // two redirects while the stale request is outstanding
    lat = 3;
    run(0, 1, 64'h8000_0200);
    check_eq("drop_hold_addr", ireq_addr, 64'h8000_0400);
    run(0, 1, 64'h8000_0303);
    run(0, 0, 0);
    run(0, 0, 0);
    check_eq("drop_second_tgt", ireq_addr, 64'h8000_0300);
    check_eq("drop_no_out", {63'd0, out_valid}, 64'd0);

    // redirect during latency cycle 2 of a 4-cycle request
    run(0, 0, 0);
    run(0, 1, 64'h8000_0100);
    check_eq("lat_hold_addr", ireq_addr, 64'h8000_0300);
    run(0, 0, 0);
    check_eq("lat_hold_addr3", ireq_addr, 64'h8000_0300);
    run(0, 0, 0);
    check_eq("lat_new_addr", ireq_addr, 64'h8000_0100);
    check_eq("lat_no_out", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 4; i++) run(0, 0, 0);
    check_eq("lat_target_out", out_pc, 64'h8000_0100);

    // PC wrap at the top of the address space
    lat = 0;
    run(0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 12; i++) begin
      run(0, 0, 0);
      if (m_out_valid && m_out_pc == 64'hFFFF_FFFF_FFFF_FFFC) break;
    end
    check_eq("wrap_out", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_addr", ireq_addr, 64'd0);

    // reset mid-latency with stray responses during reset
    lat = 3;
    run(0, 0, 0);
    run(0, 0, 0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_eq("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check_eq("rst_ireq_addr", ireq_addr, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_pc", out_pc, 64'd0);
    check_eq("rst_out_instr", {32'd0, out_instr}, 64'd0);
    stray = 1;
    for (int i = 0; i < 3; i++) run(0, 0, 0);
    resetn = 1'b1;
    run(0, 0, 0);
    check_eq("rst_restart", ireq_addr, PC_RST);

    // randomized traffic
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      logic        st, rv;
      logic [63:0] rpc;
      st  = ($urandom_range(0, 2) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      run(st, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 64-bit in-order pipeline; sits directly upstream of decode and produces the fetch_data_t-equivalent bundle (valid, pc, raw_instr) that decode consumes.
- Owns the PC, drives a single-outstanding instruction-bus request, and absorbs decode back-pressure (load-use stall) with a one-entry skid buffer.
- Handles branch/jump redirects from execute, including discarding an in-flight response.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, PC of the first fetch after reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  XLEN  request address; stable while ireq_valid=1 until accepted.
- iresp_data_ok  in  1  one-cycle pulse: the outstanding request completes this cycle.
- iresp_data  in  32  instruction word, valid with iresp_data_ok.
- stall  in  1  from decode: the current output is not consumed this cycle.
- redirect_valid  in  1  from execute: one-cycle pulse, flush and refetch.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0.
- out_valid  out  1  output bundle valid.
- out_pc  out  XLEN  PC of the output instruction.
- out_instr  out  32  raw instruction.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=FETCH; pc=PC_RESET.
  - ireq_valid=0, ireq_addr=0.
  - out_valid=0, out_pc=0, out_instr=0; skid empty.
- First rising edge with resetn=1: ireq_valid=1, ireq_addr=PC_RESET.
- Bus rules:
  - Only one request is outstanding at a time.
  - Once ireq_valid=1, it and ireq_addr hold until the cycle iresp_data_ok=1; they are never withdrawn early, including on redirect.
  - Minimum latency: data_ok in the same cycle as valid is legal.
- Output register semantics:
  - Consumed on an edge where out_valid=1 and stall=0.
  - While stall=1, out_valid/out_pc/out_instr hold exactly.
  - When the output is consumed and nothing replaces it, out_valid clears.
- States:
  - FETCH: request outstanding for pc. On data_ok without redirect:
    - If the output is free or being consumed (!out_valid | !stall): load out<={pc,iresp_data}, pc<=pc+4, next request at pc+4 issued on the same edge (back-to-back, no bubble).
    - Otherwise: capture into skid, pc<=pc+4, ireq_valid<=0, go HOLD.
  - HOLD: no request outstanding. When stall=0: out<=skid, skid cleared, ireq_valid<=1 at pc, go FETCH.
  - DROP: the request for the stale address is still outstanding. On data_ok: discard the data, ireq_valid stays 1 with ireq_addr<=pc (the target), go FETCH.
- Redirect (highest priority, overrides stall and data_ok) on any edge with redirect_valid=1:
  - out_valid<=0, skid cleared, pc<=target.
  - FETCH with data_ok same cycle: discard the data, next request at target, stay FETCH.
  - FETCH without data_ok: go DROP.
  - HOLD: ireq_valid<=1 at target, go FETCH.
  - DROP: update the target only, stay DROP.
- PC arithmetic: +4 modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Reset mid-transaction: all state clears immediately. Any response arriving after reset release without a new request is ignored, because data_ok is only honoured while ireq_valid=1.
- out_valid never asserts for a discarded or stale-address instruction.

Test Plan:
- Reset release with zero-latency bus (data_ok every cycle ireq_valid=1), stall=0 → ireq_addr 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; out_pc follows one cycle later, out_valid continuous.
- Hold stall=1 for 3 cycles while a response for 8000_0004 arrives → outputs frozen at 8000_0000; skid holds 8000_0004; ireq_valid=0; after stall drops, out_pc=8000_0004 next edge, then request 8000_0008 is issued.
- 4-cycle bus latency; redirect_valid with redirect_pc=8000_0100 in latency cycle 2 → ireq_addr stays 8000_0004 until data_ok, that data is discarded, next ireq_addr=8000_0100, out_valid=0 until it returns.
- redirect_valid coincident with data_ok and stall=1 → response discarded, out_valid=0 next cycle, ireq_addr=target next cycle.
- Two redirects (8000_0200 then 8000_0300) while in DROP → only 8000_0300 is fetched.
- Deassert resetn while ireq_valid=1 mid-latency → all outputs 0 immediately; a stray data_ok during reset produces no out_valid; after release, fetch restarts at PC_RESET.
